// File: rtl/multicycle_mainfsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// master = the FSM side, slave = the datapath/condlogic side.
interface multicycle_mainfsm_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MemReady;
    logic             IRWrite;
    logic             AdrSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             Branch;
    logic             ALUOp;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        input  Op, Funct, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State, RetireCount
    );

    modport slave (
        output Op, Funct, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State, RetireCount
    );
endinterface

// File: rtl/multicycle_mainfsm.sv
// Main sequencing FSM for the multicycle ARM-like CPU: fetch/decode/execute/writeback
// control with memory-ready stalls, illegal-opcode pulse and a retired-instruction counter.
module multicycle_mainfsm #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_mainfsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       illegal;
    } ctrl_t;

    // Moore outputs are decoded from the next state and registered, so they
    // line up with state_q and come straight off flops.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH, S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_MEMADR:   c.alu_src_b = 2'b01;
            S_MEMRD:    c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_EXECUTER: c.alu_op = 1'b1;
            S_EXECUTEI: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            S_ALUWB:    c.reg_w = 1'b1;
            S_BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            S_UNKNOWN:  c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             retire_inc;
    logic             unused_funct;

    assign unused_funct = ^bus.Funct[4:1];

    always_comb begin
        state_d    = S_FETCH;
        retire_inc = 1'b0;
        case (state_q)
            S_FETCH:    state_d = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                // A store retires only on the edge where memory accepts it.
                state_d    = bus.MemReady ? S_FETCH : S_MEMWR;
                retire_inc = bus.MemReady;
            end
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH: begin
                state_d    = S_FETCH;
                retire_inc = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
        retire_d = retire_q + CNT_W'(retire_inc);
        ctrl_d   = decode(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            ctrl_q   <= decode(S_FETCH);
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            retire_q <= retire_d;
        end
    end

    // IR load and PC+4 follow MemReady directly so a stalled fetch commits once.
    assign bus.IRWrite     = (state_q == S_FETCH) & bus.MemReady;
    assign bus.NextPC      = (state_q == S_FETCH) & bus.MemReady;
    assign bus.AdrSrc      = ctrl_q.adr_src;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ResultSrc   = ctrl_q.result_src;
    assign bus.RegW        = ctrl_q.reg_w;
    assign bus.MemW        = ctrl_q.mem_w;
    assign bus.Branch      = ctrl_q.branch;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.Illegal     = ctrl_q.illegal;
    assign bus.State       = state_q;
    assign bus.RetireCount = retire_q;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Directed bench for multicycle_mainfsm: state walks, strobes, stalls, reset and counter wrap.
module tb_multicycle_mainfsm;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_mainfsm_if #(.CNT_W(CNT_W)) bus ();
    multicycle_mainfsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.MemReady = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bus.Op = 2'b01; bus.Funct = 6'b000000;
        repeat (3) begin @(posedge clk); #1; end
        bus.MemReady = 1'b0; #1;
        checks++; if (bus.State !== 4'd5) begin errors++; $display("FAIL pre_reset_state got %0d want 5", bus.State); end
        checks++; if (bus.MemW !== 1'b1) begin errors++; $display("FAIL pre_reset_memw got %b want 1", bus.MemW); end
        checks++; if (bus.RetireCount !== 4'd1) begin errors++; $display("FAIL pre_reset_cnt got %0d want 1", bus.RetireCount); end
        reset = 1'b1; #1;
        checks++; if (bus.State !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.State); end
        checks++; if (bus.MemW !== 1'b0) begin errors++; $display("FAIL reset_memw got %b want 0", bus.MemW); end
        checks++; if (bus.RetireCount !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.RetireCount); end
        checks++; if (bus.Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", bus.Illegal); end
        @(posedge clk); #1;
        reset = 1'b0; bus.MemReady = 1'b1; #1;
        checks++; if (bus.State !== 4'd0) begin errors++; $display("FAIL post_reset_state got %0d want 0", bus.State); end
        checks++; if (bus.IRWrite !== 1'b1) begin errors++; $display("FAIL post_reset_irwrite got %b want 1", bus.IRWrite); end
        checks++; if (bus.ALUSrcB !== 2'b10) begin errors++; $display("FAIL post_reset_alusrcb got %0d want 2", bus.ALUSrcB); end
        @(posedge clk); #1;
        checks++; if (bus.State !== 4'd1) begin errors++; $display("FAIL post_reset_decode got %0d want 1", bus.State); end
    endtask

    task automatic test_add;
        int st[5];
        st = '{0, 1, 6, 8, 0};
        do_reset;
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.State !== 4'(st[i])) begin errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, bus.State, st[i]); end
            checks++; if (bus.ALUOp !== (st[i] == 6)) begin errors++; $display("FAIL add_aluop[%0d] got %b want %b", i, bus.ALUOp, st[i] == 6); end
            checks++; if (bus.RegW !== (st[i] == 8)) begin errors++; $display("FAIL add_regw[%0d] got %b want %b", i, bus.RegW, st[i] == 8); end
            checks++; if (bus.ALUSrcB !== ((st[i] <= 1) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL add_alusrcb[%0d] got %0d", i, bus.ALUSrcB); end
            checks++; if (bus.RetireCount !== ((i == 4) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL add_cnt[%0d] got %0d want %0d", i, bus.RetireCount, (i == 4) ? 1 : 0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ldr;
        int st[9];
        int mr[9];
        st = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        mr = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        do_reset;
        bus.Op = 2'b01; bus.Funct = 6'b000001;
        for (int i = 0; i < 9; i++) begin
            bus.MemReady = mr[i][0]; #1;
            checks++; if (bus.State !== 4'(st[i])) begin errors++; $display("FAIL ldr_state[%0d] got %0d want %0d", i, bus.State, st[i]); end
            checks++; if (bus.AdrSrc !== (st[i] == 3)) begin errors++; $display("FAIL ldr_adrsrc[%0d] got %b want %b", i, bus.AdrSrc, st[i] == 3); end
            checks++; if (bus.ResultSrc !== ((st[i] <= 1) ? 2'b10 : (st[i] == 4) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL ldr_resultsrc[%0d] got %0d", i, bus.ResultSrc); end
            checks++; if (bus.RegW !== (st[i] == 4)) begin errors++; $display("FAIL ldr_regw[%0d] got %b want %b", i, bus.RegW, st[i] == 4); end
            checks++; if (bus.RetireCount !== ((i == 8) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL ldr_cnt[%0d] got %0d", i, bus.RetireCount); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_str;
        int st[7];
        int mr[7];
        st = '{0, 1, 2, 5, 5, 5, 0};
        mr = '{1, 1, 1, 0, 0, 1, 1};
        do_reset;
        bus.Op = 2'b01; bus.Funct = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            bus.MemReady = mr[i][0]; #1;
            checks++; if (bus.State !== 4'(st[i])) begin errors++; $display("FAIL str_state[%0d] got %0d want %0d", i, bus.State, st[i]); end
            checks++; if (bus.MemW !== (st[i] == 5)) begin errors++; $display("FAIL str_memw[%0d] got %b want %b", i, bus.MemW, st[i] == 5); end
            checks++; if (bus.AdrSrc !== (st[i] == 5)) begin errors++; $display("FAIL str_adrsrc[%0d] got %b want %b", i, bus.AdrSrc, st[i] == 5); end
            checks++; if (bus.RetireCount !== ((i == 6) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL str_cnt[%0d] got %0d", i, bus.RetireCount); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_unknown;
        int st[4];
        st = '{0, 1, 9, 0};
        do_reset;
        bus.Op = 2'b10; bus.Funct = 6'b000000; bus.MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.State !== 4'(st[i])) begin errors++; $display("FAIL b_state[%0d] got %0d want %0d", i, bus.State, st[i]); end
            checks++; if (bus.Branch !== (st[i] == 9)) begin errors++; $display("FAIL b_branch[%0d] got %b want %b", i, bus.Branch, st[i] == 9); end
            checks++; if (bus.ALUSrcB !== ((st[i] <= 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b_alusrcb[%0d] got %0d", i, bus.ALUSrcB); end
            checks++; if (bus.RetireCount !== ((i == 3) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL b_cnt[%0d] got %0d", i, bus.RetireCount); end
            @(posedge clk); #1;
        end
        st = '{0, 1, 10, 0};
        do_reset;
        bus.Op = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.State !== 4'(st[i])) begin errors++; $display("FAIL u_state[%0d] got %0d want %0d", i, bus.State, st[i]); end
            checks++; if (bus.Illegal !== (st[i] == 10)) begin errors++; $display("FAIL u_illegal[%0d] got %b want %b", i, bus.Illegal, st[i] == 10); end
            checks++; if ((st[i] == 10) && ({bus.RegW, bus.MemW, bus.Branch, bus.ALUOp} !== 4'b0)) begin errors++; $display("FAIL u_strobes[%0d] got %b want 0000", i, {bus.RegW, bus.MemW, bus.Branch, bus.ALUOp}); end
            checks++; if (bus.RetireCount !== 4'd0) begin errors++; $display("FAIL u_cnt[%0d] got %0d want 0", i, bus.RetireCount); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap;
        do_reset;
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.MemReady = 1'b1;
        for (int n = 0; n < 16; n++) begin
            #1;
            checks++; if (bus.RetireCount !== 4'(n)) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", n, bus.RetireCount, n); end
            repeat (4) begin @(posedge clk); #1; end
        end
        checks++; if (bus.State !== 4'd0) begin errors++; $display("FAIL wrap_state got %0d want 0", bus.State); end
        checks++; if (bus.RetireCount !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", bus.RetireCount); end
    endtask

    task automatic test_fetch_wait;
        do_reset;
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.MemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.State !== 4'd0) begin errors++; $display("FAIL fw_state[%0d] got %0d want 0", i, bus.State); end
            checks++; if ({bus.IRWrite, bus.NextPC} !== 2'b00) begin errors++; $display("FAIL fw_strobe[%0d] got %b want 00", i, {bus.IRWrite, bus.NextPC}); end
            @(posedge clk); #1;
        end
        bus.MemReady = 1'b1; #1;
        checks++; if ({bus.IRWrite, bus.NextPC} !== 2'b11) begin errors++; $display("FAIL fw_accept got %b want 11", {bus.IRWrite, bus.NextPC}); end
        @(posedge clk); #1;
        checks++; if (bus.State !== 4'd1) begin errors++; $display("FAIL fw_decode got %0d want 1", bus.State); end
        checks++; if ({bus.IRWrite, bus.NextPC} !== 2'b00) begin errors++; $display("FAIL fw_once got %b want 00", {bus.IRWrite, bus.NextPC}); end
    endtask

    initial begin
        bus.Op = 2'b00; bus.Funct = 6'b000000; bus.MemReady = 1'b0;
        #12;
        test_reset;
        test_add;
        test_ldr;
        test_str;
        test_branch_unknown;
        test_wrap;
        test_fetch_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
